// File: rtl/fc_head_pkg.sv
// Shared sizing, addressing and FSM encoding for the FC classification head.
package fc_head_pkg;

  localparam int unsigned N_FEAT    = 225;
  localparam int unsigned DW        = 22;
  localparam int unsigned WW        = 16;
  localparam int unsigned ACCW      = 48;
  localparam int unsigned AW        = 8;
  localparam int unsigned PW        = DW + WW;
  localparam int unsigned BIAS_ADDR = 225;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } fc_state_t;

  function automatic logic [ACCW-1:0] sext_weight(input logic [WW-1:0] w);
    return {{(ACCW-WW){w[WW-1]}}, w};
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed feature x weight multiply, sign-extended into a 48-bit accumulator.
module fc_mac_unit
  import fc_head_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [DW-1:0]   i_feat,
  input  logic [WW-1:0]   i_weight,
  input  logic [ACCW-1:0] i_bias,
  output logic [ACCW-1:0] o_acc
);

  logic [PW-1:0]   w_feat_ext;
  logic [PW-1:0]   w_weight_ext;
  logic [PW-1:0]   w_prod;
  logic [ACCW-1:0] w_prod_ext;
  logic [ACCW-1:0] r_acc;

  // Operands are sign-extended to the product width so an unsigned multiply yields the exact signed product.
  always_comb begin
    w_feat_ext   = {{WW{i_feat[DW-1]}}, i_feat};
    w_weight_ext = {{DW{i_weight[WW-1]}}, i_weight};
    w_prod       = w_feat_ext * w_weight_ext;
    w_prod_ext   = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_bias;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fc_head_stream.sv
// Lane-score head: flattens 225 pooled features, then one bias + dot-product run per filled frame.
module fc_head_stream
  import fc_head_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_data_valid,
  input  logic [DW-1:0]   i_data_in,
  input  logic            i_w_we,
  input  logic [AW-1:0]   i_w_addr,
  input  logic [WW-1:0]   i_w_data,
  output logic            o_buffer_full,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic [ACCW-1:0] o_result_data
);

  logic [DW-1:0]   r_buf [N_FEAT];
  logic [WW-1:0]   r_wt  [N_FEAT];
  logic [ACCW-1:0] r_bias;
  logic [AW-1:0]   r_wr_idx;
  logic            r_full;
  logic            r_executed;
  fc_state_t       r_state;
  logic [AW-1:0]   r_mac_idx;
  logic            r_busy;
  logic            r_result_valid;
  logic [ACCW-1:0] r_result_data;

  logic            w_start;
  logic            w_mac_load;
  logic            w_mac_en;
  logic [DW-1:0]   w_feat;
  logic [WW-1:0]   w_weight;
  logic [ACCW-1:0] w_acc;

  always_comb begin
    w_start    = r_full && !r_executed;
    w_mac_load = !i_clear && (r_state == IDLE) && w_start;
    w_mac_en   = !i_clear && (r_state == ACC);
    w_feat     = r_buf[r_mac_idx];
    w_weight   = r_wt[r_mac_idx];
  end

  // Capture stops at the last slot; further samples are ignored until re-armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_idx <= '0;
      r_full   <= 1'b0;
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        r_buf[k] <= '0;
      end
    end else if (i_clear) begin
      r_wr_idx <= '0;
      r_full   <= 1'b0;
    end else if (i_data_valid && !r_full) begin
      r_buf[r_wr_idx] <= i_data_in;
      if (r_wr_idx == AW'(N_FEAT - 1)) begin
        r_full <= 1'b1;
      end else begin
        r_wr_idx <= r_wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bias <= '0;
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        r_wt[k] <= '0;
      end
    end else if (i_w_we && (r_state != ACC)) begin
      if (i_w_addr < AW'(N_FEAT)) begin
        r_wt[i_w_addr] <= i_w_data;
      end else if (i_w_addr == AW'(BIAS_ADDR)) begin
        r_bias <= sext_weight(i_w_data);
      end
    end
  end

  // The start condition is consumed at the edge after the buffer fills: that edge loads the bias.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_executed     <= 1'b0;
      r_mac_idx      <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else if (i_clear) begin
      r_state        <= IDLE;
      r_executed     <= 1'b0;
      r_mac_idx      <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_result_valid <= 1'b0;
          if (w_start) begin
            r_executed <= 1'b1;
            r_mac_idx  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ACC;
          end
        end
        ACC: begin
          if (r_mac_idx == AW'(N_FEAT - 1)) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_mac_idx <= r_mac_idx + 1'b1;
          end
        end
        DONE: begin
          r_result_data  <= w_acc;
          r_result_valid <= 1'b1;
          r_state        <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fc_mac_unit u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (i_clear),
    .i_load   (w_mac_load),
    .i_en     (w_mac_en),
    .i_feat   (w_feat),
    .i_weight (w_weight),
    .i_bias   (r_bias),
    .o_acc    (w_acc)
  );

  assign o_buffer_full  = r_full;
  assign o_busy         = r_busy;
  assign o_result_valid = r_result_valid;
  assign o_result_data  = r_result_data;

endmodule

// File: tb/tb_fc_head_stream.sv
// Directed bench for fc_head_stream: hand-computed lane scores, latency, busy length and re-arm behaviour.
module tb_fc_head_stream;

  logic        clk;
  logic        rst;
  logic        i_clear;
  logic        i_data_valid;
  logic [21:0] i_data_in;
  logic        i_w_we;
  logic [7:0]  i_w_addr;
  logic [15:0] i_w_data;
  logic        o_buffer_full;
  logic        o_busy;
  logic        o_result_valid;
  logic [47:0] o_result_data;

  int n_checks;
  int n_errors;

  int     lat;
  int     busy_cnt;
  int     pulses;
  longint res;

  fc_head_stream dut (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (i_clear),
    .i_data_valid   (i_data_valid),
    .i_data_in      (i_data_in),
    .i_w_we         (i_w_we),
    .i_w_addr       (i_w_addr),
    .i_w_data       (i_w_data),
    .o_buffer_full  (o_buffer_full),
    .o_busy         (o_busy),
    .o_result_valid (o_result_valid),
    .o_result_data  (o_result_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint res_s();
    return longint'($signed(o_result_data));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input int val);
    i_w_we   = 1'b1;
    i_w_addr = 8'(addr);
    i_w_data = 16'(val);
    tick();
    i_w_we   = 1'b0;
  endtask

  task automatic load_weights(input int w, input int bias);
    for (int a = 0; a < 225; a++) write_w(a, w);
    write_w(225, bias);
  endtask

  // mode 0: every sample = val; mode 1: sample i = i. Last edge of the loop is T0 for n == 225.
  task automatic feed(input int n, input int mode, input int val);
    for (int i = 0; i < n; i++) begin
      i_data_valid = 1'b1;
      i_data_in    = (mode == 1) ? 22'(i) : 22'(val);
      tick();
    end
    i_data_valid = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  // Bounded observation window; latency counts edges from the call point.
  task automatic watch(input int edges);
    lat = -1; busy_cnt = 0; pulses = 0; res = 0;
    for (int n = 1; n <= edges; n++) begin
      tick();
      if (o_busy) busy_cnt++;
      if (o_result_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = res_s();
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; i_clear = 1'b0; i_data_valid = 1'b0; i_data_in = '0;
    i_w_we = 1'b0; i_w_addr = '0; i_w_data = '0;
    #12;
    check("reset_full",   longint'(o_buffer_full), 0);
    check("reset_busy",   longint'(o_busy), 0);
    check("reset_valid",  longint'(o_result_valid), 0);
    check("reset_result", res_s(), 0);
    rst = 1'b1;
    tick();

    // Test 1: ones x ones -> 225, latency T0+227, busy 225 cycles
    load_weights(1, 0);
    feed(224, 0, 1);
    check("t1_not_full_224", longint'(o_buffer_full), 0);
    feed(1, 0, 1);
    check("t1_full_at_t0", longint'(o_buffer_full), 1);
    check("t1_busy_at_t0", longint'(o_busy), 0);
    watch(300);
    check("t1_pulses",  pulses, 1);
    check("t1_latency", lat, 227);
    check("t1_busy",    busy_cnt, 225);
    check("t1_result",  res, 225);
    check("t1_hold",    res_s(), 225);

    // Test 2: ramp samples; a weight write during ACC must be dropped
    do_clear();
    check("t2_clear_result", res_s(), 0);
    check("t2_clear_full",   longint'(o_buffer_full), 0);
    feed(225, 1, 0);
    tick(); tick(); tick();
    check("t2_busy_mid", longint'(o_busy), 1);
    write_w(1, 50);
    watch(300);
    check("t2_pulses", pulses, 1);
    check("t2_result", res, 25200);

    // Test 3: bias 5, weights -2, samples 3
    do_clear();
    load_weights(-2, 5);
    feed(225, 0, 3);
    watch(300);
    check("t3_pulses", pulses, 1);
    check("t3_result", res, -1345);

    // Test 4: extreme magnitudes
    do_clear();
    load_weights(-32768, 0);
    feed(225, 0, -2097152);
    watch(300);
    check("t4_pulses", pulses, 1);
    check("t4_busy",   busy_cnt, 225);
    check("t4_result", res, 64'sd15461882265600);

    // Test 5: 230 samples, extras ignored
    do_clear();
    load_weights(1, 0);
    feed(230, 1, 0);
    watch(300);
    check("t5_pulses", pulses, 1);
    check("t5_result", res, 25200);

    // Test 6: reset at T0+100 aborts the run
    do_clear();
    feed(225, 0, 1);
    repeat (100) tick();
    check("t6_busy_before_rst", longint'(o_busy), 1);
    rst = 1'b0;
    #1;
    check("t6_rst_full",   longint'(o_buffer_full), 0);
    check("t6_rst_busy",   longint'(o_busy), 0);
    check("t6_rst_valid",  longint'(o_result_valid), 0);
    check("t6_rst_result", res_s(), 0);
    tick();
    rst = 1'b1;
    watch(300);
    check("t6_no_pulse", pulses, 0);
    load_weights(1, 7);
    feed(225, 0, 2);
    watch(300);
    check("t6_refill_pulses", pulses, 1);
    check("t6_refill_result", res, 457);

    // Clear with a simultaneous sample: the sample is dropped
    i_data_valid = 1'b1;
    i_data_in    = 22'd9;
    do_clear();
    i_data_valid = 1'b0;
    check("t6_clear_result", res_s(), 0);
    feed(224, 0, 1);
    check("t6_clear_drop", longint'(o_buffer_full), 0);
    feed(1, 0, 1);
    watch(300);
    check("t6_second_pulses", pulses, 1);
    check("t6_second_result", res, 232);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
